// File: rtl/i2c_bus_arbiter.sv
// Two-port round-robin arbiter feeding one I2C write master.
// Buffers one three-byte write per port and waits out the master's busy window.
module i2c_bus_arbiter #(
  parameter int unsigned BUSY_TIMEOUT = 15,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_start,
  input  logic [6:0] req0_address,
  input  logic [7:0] req0_data_0,
  input  logic [7:0] req0_data_1,
  output logic       req0_busy,
  output logic       req0_done,
  input  logic       req1_start,
  input  logic [6:0] req1_address,
  input  logic [7:0] req1_data_0,
  input  logic [7:0] req1_data_1,
  output logic       req1_busy,
  output logic       req1_done,
  input  logic       i2c_busy,
  output logic       i2c_start,
  output logic [6:0] address,
  output logic [7:0] data_0,
  output logic [7:0] data_1,
  output logic       owner,
  output logic       timeout_err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0][6:0]  slot_addr_q, slot_addr_d;
  logic [1:0][7:0]  slot_d0_q, slot_d0_d;
  logic [1:0][7:0]  slot_d1_q, slot_d1_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       dat0_q, dat0_d;
  logic [7:0]       dat1_q, dat1_d;
  logic             start_q, start_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             grant;
  logic             complete;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    slot_addr_d = slot_addr_q;
    slot_d0_d   = slot_d0_q;
    slot_d1_d   = slot_d1_q;
    addr_d      = addr_q;
    dat0_d      = dat0_q;
    dat1_d      = dat1_q;
    start_d     = 1'b0;
    owner_d     = owner_q;
    last_d      = last_q;
    done_d      = '0;
    tmo_d       = 1'b0;
    grant       = 1'b0;
    complete    = 1'b0;

    // Requests only land in an empty slot; a busy slot keeps its contents.
    if (!pend_q[0] && req0_start) begin
      pend_d[0]      = 1'b1;
      slot_addr_d[0] = req0_address;
      slot_d0_d[0]   = req0_data_0;
      slot_d1_d[0]   = req0_data_1;
    end
    if (!pend_q[1] && req1_start) begin
      pend_d[1]      = 1'b1;
      slot_addr_d[1] = req1_address;
      slot_d0_d[1]   = req1_data_0;
      slot_d1_d[1]   = req1_data_1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          grant   = (pend_q == 2'b11) ? ~last_q : pend_q[1];
          addr_d  = slot_addr_q[grant];
          dat0_d  = slot_d0_q[grant];
          dat1_d  = slot_d1_q[grant];
          owner_d = grant;
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i2c_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TMO_LAST) begin
          complete = 1'b1;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!i2c_busy) complete = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      done_d[owner_q] = 1'b1;
      pend_d[owner_q] = 1'b0;
      last_d          = owner_q;
      state_d         = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      slot_addr_q <= '0;
      slot_d0_q   <= '0;
      slot_d1_q   <= '0;
      addr_q      <= '0;
      dat0_q      <= '0;
      dat1_q      <= '0;
      start_q     <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      done_q      <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      slot_addr_q <= slot_addr_d;
      slot_d0_q   <= slot_d0_d;
      slot_d1_q   <= slot_d1_d;
      addr_q      <= addr_d;
      dat0_q      <= dat0_d;
      dat1_q      <= dat1_d;
      start_q     <= start_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
    end
  end

  assign req0_busy   = pend_q[0];
  assign req1_busy   = pend_q[1];
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign i2c_start   = start_q;
  assign address     = addr_q;
  assign data_0      = dat0_q;
  assign data_1      = dat1_q;
  assign owner       = owner_q;
  assign timeout_err = tmo_q;

endmodule
